math_log2_34: RTL and testbench



---
 rtl/math_log2_pkg.sv | 44 ++++
 rtl/math_lzc34.sv | 20 ++
 rtl/math_log2_34.sv | 103 ++++++++++
 tb/tb_math_log2_34.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/math_log2_pkg.sv
// Shared constants, log2 mantissa table and stage bundles for math_log2_34.
// LOG2_LUT[j] = round(1024*log2(1+j/64)), j = 0..64.
package math_log2_pkg;

    localparam int DIN_W  = 34;
    localparam int DOUT_W = 12;
    localparam int FRAC_W = 6;

    localparam logic [10:0] LOG2_LUT [0:64] = '{
        11'd0,    11'd23,   11'd45,   11'd68,
        11'd90,   11'd111,  11'd132,  11'd153,
        11'd174,  11'd194,  11'd214,  11'd234,
        11'd254,  11'd273,  11'd292,  11'd311,
        11'd330,  11'd348,  11'd366,  11'd384,
        11'd402,  11'd419,  11'd436,  11'd454,
        11'd470,  11'd487,  11'd504,  11'd520,
        11'd536,  11'd552,  11'd568,  11'd584,
        11'd599,  11'd614,  11'd629,  11'd644,
        11'd659,  11'd674,  11'd689,  11'd703,
        11'd717,  11'd731,  11'd745,  11'd759,
        11'd773,  11'd787,  11'd800,  11'd813,
        11'd827,  11'd840,  11'd853,  11'd866,
        11'd879,  11'd891,  11'd904,  11'd916,
        11'd929,  11'd941,  11'd953,  11'd965,
        11'd977,  11'd989,  11'd1001, 11'd1012,
        11'd1024
    };

    // detect -> normalize
    typedef struct packed {
        logic [33:0] din;
        logic [5:0]  e;
        logic        z;
    } s1_t;

    // normalize -> LUT/interpolate
    typedef struct packed {
        logic [5:0] e;
        logic [5:0] k;
        logic [3:0] t;
        logic       z;
    } s2_t;

endpackage

// File: rtl/math_lzc34.sv
// Combinational highest-set-bit encoder for a 34-bit operand.
// Ports: din (operand), idx (index of top set bit, 0 if none), zero (din == 0).
module math_lzc34
    import math_log2_pkg::*;
(
    input  logic [33:0] din,
    output logic [5:0]  idx,
    output logic        zero
);

    always_comb begin
        idx = '0;
        for (int i = 0; i < DIN_W; i++) begin
            if (din[i]) idx = 6'(i);
        end
    end

    assign zero = ~|din;

endmodule

// File: rtl/math_log2_34.sv
// Three-stage pipelined log2: 34-bit unsigned in, unsigned Q6.6 out.
// Ports: clk, reset_n, in_valid/in_ready/din, out_valid/out_ready/dout/out_zero.
module math_log2_34
    import math_log2_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [33:0] din,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] dout,
    output logic        out_zero
);

    // Single global advance: every stage moves together or holds.
    logic ce;
    assign ce       = !out_valid || out_ready;
    assign in_ready = ce;

    // ---------------- stage 1: detect ----------------
    logic [5:0] lz_idx;
    logic       lz_zero;

    math_lzc34 u_lzc (
        .din  (din),
        .idx  (lz_idx),
        .zero (lz_zero)
    );

    logic v1;
    s1_t  s1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1 <= 1'b0;
            s1 <= '0;
        end else if (ce) begin
            v1     <= in_valid;
            s1.din <= din;
            s1.e   <= lz_idx;
            s1.z   <= lz_zero;
        end
    end

    // ---------------- stage 2: normalize ----------------
    // Only n[32:23] is needed: the 10 bits just below the leading one.
    logic [5:0] sh;
    logic [9:0] nf;

    assign sh = 6'd33 - s1.e;
    assign nf = 10'((s1.din << sh) >> 23);

    logic v2;
    s2_t  s2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v2 <= 1'b0;
            s2 <= '0;
        end else if (ce) begin
            v2   <= v1;
            s2.e <= s1.e;
            s2.k <= nf[9:4];
            s2.t <= nf[3:0];
            s2.z <= s1.z;
        end
    end

    // ---------------- stage 3: LUT, interpolate, round ----------------
    logic [10:0] lk;
    logic [10:0] lk1;
    logic [10:0] dl;
    logic [14:0] prod;
    logic [10:0] f10;
    logic [6:0]  f6;
    logic [11:0] res;

    always_comb begin
        lk   = LOG2_LUT[s2.k];
        lk1  = LOG2_LUT[7'(s2.k) + 7'd1];
        dl   = lk1 - lk;
        prod = 15'(dl) * 15'(s2.t);
        f10  = lk + 11'(prod >> 4);
        f6   = 7'((12'(f10) + 12'd8) >> 4);
        // f6 == 64 carries straight into the integer field.
        res  = {s2.e, {FRAC_W{1'b0}}} + 12'(f6);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            dout      <= '0;
            out_zero  <= 1'b0;
        end else if (ce) begin
            out_valid <= v2;
            dout      <= s2.z ? 12'd0 : res;
            out_zero  <= s2.z;
        end
    end

endmodule

// File: tb/tb_math_log2_34.sv
// Self-checking bench for math_log2_34: directed vectors, stall, reset,
// and a random stream scoreboarded against the log2 formula.
module tb_math_log2_34;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [33:0] din = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] dout;
    logic        out_zero;

    math_log2_34 dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int          lut [0:64];
    logic [33:0] pend [$];
    logic [12:0] outs [$];
    logic        last_ov;
    logic        last_ix;
    logic        hold_v = 1'b0;
    logic [12:0] hold_d = '0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    function automatic logic [12:0] model(input logic [33:0] x);
        int          e;
        logic [33:0] n;
        int          k;
        int          t;
        int          f10;
        int          f6;
        e = 0;
        if (x == 0) return 13'h1000;
        for (int i = 0; i < 34; i++) if (x[i]) e = i;
        n   = x << (33 - e);
        k   = int'(n[32:27]);
        t   = int'(n[26:23]);
        f10 = lut[k] + (((lut[k+1] - lut[k]) * t) >> 4);
        f6  = (f10 + 8) >> 4;
        return {1'b0, 12'(64 * e + f6)};
    endfunction

    // One clock cycle: drive, sample mid-cycle, score, advance.
    task automatic cyc(input logic iv, input logic [33:0] d,
                       input logic ordy);
        logic [33:0] x;
        real         r;
        real         df;
        in_valid  = iv;
        din       = d;
        out_ready = ordy;
        #1;
        chk("inrdy", in_ready, !out_valid || ordy);
        if (hold_v)
            chk("stable", {out_valid, out_zero, dout}, {1'b1, hold_d});
        last_ov = out_valid;
        last_ix = iv && in_ready;
        if (out_valid && ordy) begin
            if (pend.size() == 0) begin
                chk("spurious", 1, 0);
            end else begin
                x = pend.pop_front();
                chk("sb", {out_zero, dout}, model(x));
                if (x != 0) begin
                    r  = 64.0 * $ln(real'(x)) / $ln(2.0);
                    df = real'(dout) - r;
                    chk("abs", (df <= 1.0 && df >= -1.0), 1);
                end
            end
            outs.push_back({out_zero, dout});
        end
        hold_v = out_valid && !ordy;
        hold_d = {out_zero, dout};
        if (last_ix) pend.push_back(d);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (pend.size() > 0 && g < 50) begin
            cyc(1'b0, '0, 1'b1);
            g++;
        end
        chk("drain", pend.size(), 0);
    endtask

    logic [33:0] p2_din [3] = '{34'd1, 34'd2, 34'h2_0000_0000};
    int          p2_exp [3] = '{0, 64, 2112};
    logic [33:0] hv_din [4] = '{34'd3, 34'h3_FFFF_FFFF, 34'd0, 34'd1};
    logic [12:0] hv_exp [4] = '{13'd101, 13'd2176, 13'h1000, 13'd0};
    int          bp_exp [8] = '{0, 64, 101, 128, 149, 165, 180, 192};

    initial begin
        int          lat;
        int          sent;
        logic [63:0] rr;
        logic [33:0] d;

        for (int j = 0; j <= 64; j++)
            lut[j] = int'($floor(1024.0 * $ln(1.0 + j / 64.0)
                                 / $ln(2.0) + 0.5));

        #1 reset_n = 1'b0;
        #1;
        chk("rst_ov", out_valid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_zero", out_zero, 0);
        chk("rst_rdy", in_ready, 1);
        #10 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // powers of two, latency
        for (int i = 0; i < 3; i++) begin
            outs.delete();
            cyc(1'b1, p2_din[i], 1'b1);
            lat = 0;
            do begin
                lat++;
                cyc(1'b0, '0, 1'b1);
            end while (!last_ov && lat < 8);
            chk("lat", lat, 3);
            chk("pow2", outs.size() > 0 ? outs[0] : 13'h1fff,
                13'(p2_exp[i]));
        end

        // interpolation, carry, zero handling
        outs.delete();
        for (int i = 0; i < 4; i++) cyc(1'b1, hv_din[i], 1'b1);
        drain();
        chk("hv_cnt", outs.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("hv", i < outs.size() ? outs[i] : 13'h1fff, hv_exp[i]);

        // backpressure: 8 values, 5-cycle stall mid-stream
        outs.delete();
        sent = 0;
        for (int c = 0; c < 40 && outs.size() < 8; c++) begin
            cyc(sent < 8, 34'(sent + 1), !(c >= 4 && c < 9));
            if (last_ix) sent++;
        end
        chk("bp_cnt", outs.size(), 8);
        for (int i = 0; i < 8; i++)
            chk("bp", i < outs.size() ? outs[i] : 13'h1fff,
                13'(bp_exp[i]));

        // reset with items in flight
        for (int i = 0; i < 3; i++) cyc(1'b1, 34'd10, 1'b1);
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("mrst_ov", out_valid, 0);
        chk("mrst_dout", dout, 0);
        chk("mrst_zero", out_zero, 0);
        chk("mrst_rdy", in_ready, 1);
        pend.delete();
        outs.delete();
        hold_v = 1'b0;
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, '0, 1'b1);
            chk("mrst_idle", last_ov, 0);
        end

        // random stream
        for (int i = 0; i < 3000; i++) begin
            rr = {$urandom(), $urandom()};
            case ($urandom_range(0, 3))
                0: d = rr[33:0];
                1: d = rr[33:0] >> $urandom_range(0, 33);
                2: d = 34'd1 << $urandom_range(0, 33);
                default: d = 34'($urandom_range(0, 20));
            endcase
            cyc($urandom_range(0, 3) != 0, d, $urandom_range(0, 9) < 7);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
